// File: rtl/ad9228_pkg.sv
// Shared types for the AD9228 event packer: FSM states, the 48-bit sample layout
// and the helpers that split one sample into two 32-bit stream words.
package ad9228_pkg;

   typedef enum logic [1:0] {IDLE, HEADER, DATA, TRAILER} state_t;

   typedef struct packed {
      logic [11:0] ch3;
      logic [11:0] ch2;
      logic [11:0] ch1;
      logic [11:0] ch0;
   } sample_t;

   localparam logic [15:0] HEADER_MARKER_DEFAULT = 16'hA5A5;

   function automatic logic [31:0] lo_word(input sample_t s);
      return {4'h0, s.ch1, 4'h0, s.ch0};
   endfunction

   function automatic logic [31:0] hi_word(input sample_t s);
      return {4'h0, s.ch3, 4'h0, s.ch2};
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO: rd_data always shows the head entry
// while empty is low; pointers carry one extra wrap bit for full/empty.
module sync_fifo #(
   parameter int WIDTH = 48,
   parameter int DEPTH = 2048
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign do_wr = wr_en & ~full;
   assign do_rd = rd_en & ~empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage is data only, so it carries no reset.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   assign rd_data = mem[rd_ptr[AW-1:0]];
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/ad9228_event_packer.sv
// Captures AD9228 samples during a read window and streams them as one AXI4-Stream
// packet: header, two words per sample, trailer with overflow flag and sample count.
module ad9228_event_packer
   import ad9228_pkg::*;
#(
   parameter int          TRIGGER_COUNTER_LENGTH = 16,
   parameter int          FIFO_DEPTH             = 2048,
   parameter logic [15:0] HEADER_MARKER          = HEADER_MARKER_DEFAULT
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              read_en,
   input  logic [47:0]                       adc_data,
   input  logic [TRIGGER_COUNTER_LENGTH-1:0] trigger_counter,
   output logic [31:0]                       m_axis_tdata,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   output logic                              m_axis_tlast,
   output logic                              busy,
   output logic [7:0]                        dropped_events
);

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   state_t  state_q, state_d;
   logic    read_en_q;
   logic    capturing_q;
   logic    capture_done_q;
   logic    overflow_q;
   logic    half_q;
   logic [15:0] sample_count_q;
   logic [7:0]  dropped_q;
   logic [TRIGGER_COUNTER_LENGTH-1:0] trig_q;
   logic [15:0] trig_ext;

   logic    rise, start, reject, cap_cycle;
   logic    fifo_wr, fifo_rd, fifo_full, fifo_empty;
   sample_t fifo_head;
   logic    handshake;

   assign rise      = read_en & ~read_en_q;
   assign start     = rise & (state_q == IDLE);
   assign reject    = rise & (state_q != IDLE);
   // The start cycle itself carries a valid sample.
   assign cap_cycle = start | (capturing_q & read_en);
   assign fifo_wr   = cap_cycle & ~fifo_full;
   assign handshake = m_axis_tvalid & m_axis_tready;
   assign trig_ext  = 16'(trig_q);

   sync_fifo #(
      .WIDTH (48),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (fifo_wr),
      .wr_data (adc_data),
      .rd_en   (fifo_rd),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         read_en_q      <= 1'b0;
         capturing_q    <= 1'b0;
         capture_done_q <= 1'b0;
         overflow_q     <= 1'b0;
         half_q         <= 1'b0;
         sample_count_q <= '0;
         dropped_q      <= '0;
      end else begin
         state_q   <= state_d;
         read_en_q <= read_en;

         if (start) begin
            capturing_q <= 1'b1;
         end else if (capturing_q && !read_en) begin
            capturing_q    <= 1'b0;
            capture_done_q <= 1'b1;
         end else if (state_q == TRAILER && m_axis_tready) begin
            capture_done_q <= 1'b0;
         end

         if (cap_cycle && fifo_full)
            overflow_q <= 1'b1;
         else if (state_q == TRAILER && m_axis_tready)
            overflow_q <= 1'b0;

         if (start)
            sample_count_q <= fifo_wr ? 16'd1 : 16'd0;
         else if (fifo_wr)
            sample_count_q <= sat_inc16(sample_count_q);

         if (reject) dropped_q <= sat_inc8(dropped_q);

         if (state_q == DATA && handshake) half_q <= ~half_q;
      end
   end

   // Event number is pure data, latched only when an event is accepted.
   always_ff @(posedge clk) begin
      if (start) trig_q <= trigger_counter;
   end

   always_comb begin
      state_d       = state_q;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tlast  = 1'b0;
      fifo_rd       = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = HEADER;
         end
         HEADER: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = {HEADER_MARKER, trig_ext};
            if (m_axis_tready) state_d = DATA;
         end
         DATA: begin
            // Head entry stays put until its second word is accepted.
            if (!fifo_empty) begin
               m_axis_tvalid = 1'b1;
               m_axis_tdata  = half_q ? hi_word(fifo_head) : lo_word(fifo_head);
               fifo_rd       = half_q & m_axis_tready;
            end else if (capture_done_q) begin
               state_d = TRAILER;
            end
         end
         TRAILER: begin
            m_axis_tvalid = 1'b1;
            m_axis_tlast  = 1'b1;
            m_axis_tdata  = {overflow_q, 15'b0, sample_count_q};
            if (m_axis_tready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy           = (state_q != IDLE);
   assign dropped_events = dropped_q;

endmodule

// File: tb/tb_ad9228_event_packer.sv
// Directed bench for ad9228_event_packer: expected stream words are queued as stimulus
// is driven and compared as the DUT hands them over.
module tb_ad9228_event_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic        read_en, read_en_s;
   logic [47:0] adc_data;
   logic [15:0] trigger_counter;
   logic        tready, tready_s;
   logic [31:0] tdata, tdata_s;
   logic        tvalid, tvalid_s, tlast, tlast_s, busy, busy_s;
   logic [7:0]  dropped, dropped_s;

   int          vec = 0;
   int          miscompares = 0;
   int          words_seen = 0;
   int          words_before;
   bit          rand_mode = 1'b0;
   logic [32:0] exp_q[$];
   logic [32:0] exp_s[$];

   always #5 clk = ~clk;

   ad9228_event_packer dut (
      .clk             (clk),
      .rst             (rst),
      .read_en         (read_en),
      .adc_data        (adc_data),
      .trigger_counter (trigger_counter),
      .m_axis_tdata    (tdata),
      .m_axis_tvalid   (tvalid),
      .m_axis_tready   (tready),
      .m_axis_tlast    (tlast),
      .busy            (busy),
      .dropped_events  (dropped)
   );

   ad9228_event_packer #(.FIFO_DEPTH(16)) dut_small (
      .clk             (clk),
      .rst             (rst),
      .read_en         (read_en_s),
      .adc_data        (adc_data),
      .trigger_counter (trigger_counter),
      .m_axis_tdata    (tdata_s),
      .m_axis_tvalid   (tvalid_s),
      .m_axis_tready   (tready_s),
      .m_axis_tlast    (tlast_s),
      .busy            (busy_s),
      .dropped_events  (dropped_s)
   );

   function automatic logic [31:0] lo_w(input logic [47:0] d);
      return {4'h0, d[23:12], 4'h0, d[11:0]};
   endfunction

   function automatic logic [31:0] hi_w(input logic [47:0] d);
      return {4'h0, d[47:36], 4'h0, d[35:24]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vec++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      if (rand_mode) tready = 1'($urandom_range(0, 1));
   endtask

   task automatic run_event(input int n, input logic [15:0] trg, input bit fixed,
                            input logic [47:0] fixed_data);
      exp_q.push_back({1'b0, 16'hA5A5, trg});
      read_en = 1'b1;
      trigger_counter = trg;
      for (int i = 0; i < n; i++) begin
         adc_data = fixed ? fixed_data : 48'({$urandom, $urandom});
         exp_q.push_back({1'b0, lo_w(adc_data)});
         exp_q.push_back({1'b0, hi_w(adc_data)});
         cycle();
      end
      read_en = 1'b0;
      exp_q.push_back({1'b1, 16'h0000, 16'(n)});
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 20000; i++) begin
         if (exp_q.size() == 0 && busy === 1'b0) break;
         cycle();
      end
      chk(tag, 64'(exp_q.size() == 0 && busy === 1'b0), 64'd1);
   endtask

   // Scoreboard and AXI stability monitor for the main instance.
   initial begin
      logic        prev_stall;
      logic [32:0] prev_word;
      logic [32:0] e;
      prev_stall = 1'b0;
      prev_word  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               vec++;
               assert (tvalid === 1'b1 && {tlast, tdata} === prev_word) else begin
                  miscompares++;
                  $error("FAIL stall_hold: observed v=%b %h expected v=1 %h", tvalid, {tlast, tdata}, prev_word);
               end
            end
            if (tvalid === 1'b1 && tready === 1'b1) begin
               vec++;
               if (exp_q.size() == 0) begin
                  miscompares++;
                  $error("FAIL extra_word: observed %h expected none", {tlast, tdata});
               end else begin
                  e = exp_q.pop_front();
                  assert ({tlast, tdata} === e) else begin
                     miscompares++;
                     $error("FAIL stream_word: observed %h expected %h", {tlast, tdata}, e);
                  end
               end
               words_seen++;
            end
            prev_stall = (tvalid === 1'b1) && (tready !== 1'b1);
            prev_word  = {tlast, tdata};
         end
      end
   end

   // Scoreboard for the shallow-FIFO instance.
   initial begin
      logic [32:0] e;
      forever begin
         @(negedge clk);
         if (!rst && tvalid_s === 1'b1 && tready_s === 1'b1) begin
            vec++;
            if (exp_s.size() == 0) begin
               miscompares++;
               $error("FAIL small_extra: observed %h expected none", {tlast_s, tdata_s});
            end else begin
               e = exp_s.pop_front();
               assert ({tlast_s, tdata_s} === e) else begin
                  miscompares++;
                  $error("FAIL small_word: observed %h expected %h", {tlast_s, tdata_s}, e);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      read_en = 1'b0;
      read_en_s = 1'b0;
      tready = 1'b0;
      tready_s = 1'b0;
      adc_data = '0;
      trigger_counter = '0;
      #3;
      chk("rst_tvalid", 64'(tvalid), 64'd0);
      chk("rst_tlast", 64'(tlast), 64'd0);
      chk("rst_tdata", 64'(tdata), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_dropped", 64'(dropped), 64'd0);
      repeat (3) cycle();
      rst = 1'b0;
      repeat (2) cycle();

      // Nominal 1280-sample event with the sink always ready.
      tready = 1'b1;
      words_before = words_seen;
      run_event(1280, 16'h0007, 1'b0, '0);
      drain("nominal_drain");
      chk("nominal_words", 64'(words_seen - words_before), 64'd2562);

      // Same event under random backpressure.
      rand_mode = 1'b1;
      words_before = words_seen;
      run_event(1280, 16'h0007, 1'b0, '0);
      drain("bp_drain");
      rand_mode = 1'b0;
      tready = 1'b1;
      chk("bp_words", 64'(words_seen - words_before), 64'd2562);

      // Retrigger while the first event is still streaming.
      run_event(200, 16'h0100, 1'b0, '0);
      repeat (10) cycle();
      chk("retrig_busy", 64'(busy), 64'd1);
      read_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         adc_data = 48'({$urandom, $urandom});
         cycle();
      end
      read_en = 1'b0;
      cycle();
      chk("retrig_dropped", 64'(dropped), 64'd1);
      drain("retrig_drain");
      chk("retrig_dropped_end", 64'(dropped), 64'd1);

      // Single-sample event.
      run_event(1, 16'h0002, 1'b1, 48'h123456789ABC);
      drain("one_drain");

      // Reset in the middle of DATA.
      run_event(100, 16'h0003, 1'b0, '0);
      repeat (20) cycle();
      chk("mid_busy_before", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_tvalid", 64'(tvalid), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_tdata", 64'(tdata), 64'd0);
      exp_q.delete();
      repeat (2) cycle();
      rst = 1'b0;
      chk("mid_rst_dropped", 64'(dropped), 64'd0);
      cycle();
      run_event(10, 16'h0055, 1'b0, '0);
      drain("post_rst_drain");

      // Overflow on the 16-deep instance: sink stalled for the whole capture.
      tready_s = 1'b0;
      trigger_counter = 16'h0009;
      exp_s.push_back({1'b0, 16'hA5A5, 16'h0009});
      read_en_s = 1'b1;
      for (int i = 0; i < 40; i++) begin
         adc_data = 48'({$urandom, $urandom});
         if (i < 16) begin
            exp_s.push_back({1'b0, lo_w(adc_data)});
            exp_s.push_back({1'b0, hi_w(adc_data)});
         end
         cycle();
      end
      read_en_s = 1'b0;
      exp_s.push_back({1'b1, 32'h80000010});
      repeat (5) cycle();
      tready_s = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         if (exp_s.size() == 0 && busy_s === 1'b0) break;
         cycle();
      end
      chk("ovf_drain", 64'(exp_s.size() == 0 && busy_s === 1'b0), 64'd1);

      repeat (3) cycle();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miscompares);
      $finish;
   end

endmodule
